pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage LC-3b pipeline. It gates the load enables of the PC and the four pipeline registers, and inserts bubbles on load-use hazards, taken control transfers and cache misses. It also sequences the two-access MEM stage of LDI/STI through a small FSM. It sits beside the forwarding unit: forwarding covers EX/MEM-to-EX dependencies, and this block stalls only where forwarding cannot resolve a hazard.

---
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage LC-3b pipeline.
// Gates the PC and pipeline-register load enables, inserts bubbles on load-use
// hazards, taken control transfers and cache misses, and steps the two-access
// MEM stage of LDI/STI.
// Optional feature macro: STALL_CNT_EN enables the saturating stall/flush
// performance counters. When it is undefined, both counters read as zero.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       IF_ID_sr1,
  input  logic [2:0]       IF_ID_sr2,
  input  logic             IF_ID_use_sr1,
  input  logic             IF_ID_use_sr2,
  input  logic             ID_EX_mem_read,
  input  logic [2:0]       ID_EX_dest,
  input  logic             EX_MEM_mem_op,
  input  logic             EX_MEM_indirect,
  input  logic             EX_MEM_br_taken,
  input  logic             imem_resp,
  input  logic             dmem_resp,
  output logic             pc_load,
  output logic             IF_ID_load,
  output logic             ID_EX_load,
  output logic             EX_MEM_load,
  output logic             MEM_WB_load,
  output logic             IF_ID_bubble,
  output logic             ID_EX_bubble,
  output logic             EX_MEM_bubble,
  output logic             pc_sel_target,
  output logic             dmem_req,
  output logic             ind_phase2,
  output logic             ind_ptr_load,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    IND_FIRST  = 2'd1,
    IND_SECOND = 2'd2
  } mem_state_e;

  mem_state_e state_q, state_d;
  logic       mem_done;
  logic       load_use;
  logic       flush;

  // Next state of the indirect-access sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MEM_IDLE:   if (EX_MEM_indirect) state_d = IND_FIRST;
      IND_FIRST:  if (dmem_resp)       state_d = IND_SECOND;
      IND_SECOND: if (dmem_resp)       state_d = MEM_IDLE;
      default:                         state_d = MEM_IDLE;
    endcase
  end

  // Indirect-access state register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MEM_IDLE;
    else     state_q <= state_d;
  end

  // MEM completion and hazard detection.
  always_comb begin
    if (!EX_MEM_mem_op)       mem_done = 1'b1;
    else if (EX_MEM_indirect) mem_done = (state_q == IND_SECOND) && dmem_resp;
    else                      mem_done = dmem_resp;
    load_use = ID_EX_mem_read &&
               ((IF_ID_use_sr1 && (IF_ID_sr1 == ID_EX_dest)) ||
                (IF_ID_use_sr2 && (IF_ID_sr2 == ID_EX_dest)));
    flush    = !rst && EX_MEM_br_taken && mem_done;
  end

  // Prioritised load-enable / bubble generation.
  always_comb begin
    pc_load       = 1'b1;
    IF_ID_load    = 1'b1;
    ID_EX_load    = 1'b1;
    EX_MEM_load   = 1'b1;
    MEM_WB_load   = 1'b1;
    IF_ID_bubble  = 1'b0;
    ID_EX_bubble  = 1'b0;
    EX_MEM_bubble = 1'b0;
    pc_sel_target = 1'b0;
    if (rst) begin
      pc_load       = 1'b0;
      IF_ID_load    = 1'b0;
      ID_EX_load    = 1'b0;
      EX_MEM_load   = 1'b0;
      MEM_WB_load   = 1'b0;
      IF_ID_bubble  = 1'b1;
      ID_EX_bubble  = 1'b1;
      EX_MEM_bubble = 1'b1;
    end else if (EX_MEM_mem_op && !mem_done) begin
      pc_load     = 1'b0;
      IF_ID_load  = 1'b0;
      ID_EX_load  = 1'b0;
      EX_MEM_load = 1'b0;
      MEM_WB_load = 1'b0;
    end else if (EX_MEM_br_taken) begin
      pc_sel_target = 1'b1;
      IF_ID_bubble  = 1'b1;
      ID_EX_bubble  = 1'b1;
      EX_MEM_bubble = 1'b1;
    end else if (load_use) begin
      pc_load      = 1'b0;
      IF_ID_load   = 1'b0;
      ID_EX_bubble = 1'b1;
    end else if (!imem_resp) begin
      pc_load      = 1'b0;
      IF_ID_bubble = 1'b1;
    end
  end

  // Memory-side strobes, forced quiet while reset is held.
  always_comb begin
    dmem_req     = !rst && EX_MEM_mem_op;
    ind_phase2   = (state_q == IND_SECOND);
    ind_ptr_load = !rst && (state_q == IND_FIRST) && dmem_resp;
  end

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_load && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush && (flush_q != '1))    flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a
// behavioural model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;
  localparam int unsigned CW = 4;
`ifdef STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk, rst;
  logic [2:0] sr1, sr2, dest;
  logic use1, use2, mrd, mop, ind, br, imem, dresp;
  logic pc_load, IF_ID_load, ID_EX_load, EX_MEM_load, MEM_WB_load;
  logic IF_ID_bubble, ID_EX_bubble, EX_MEM_bubble, pc_sel_target;
  logic dmem_req, ind_phase2, ind_ptr_load;
  logic [CW-1:0] stall_cycles, flush_count;
  logic [11:0] dut_out;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_sr1(sr1), .IF_ID_sr2(sr2),
    .IF_ID_use_sr1(use1), .IF_ID_use_sr2(use2),
    .ID_EX_mem_read(mrd), .ID_EX_dest(dest),
    .EX_MEM_mem_op(mop), .EX_MEM_indirect(ind), .EX_MEM_br_taken(br),
    .imem_resp(imem), .dmem_resp(dresp),
    .pc_load(pc_load), .IF_ID_load(IF_ID_load), .ID_EX_load(ID_EX_load),
    .EX_MEM_load(EX_MEM_load), .MEM_WB_load(MEM_WB_load),
    .IF_ID_bubble(IF_ID_bubble), .ID_EX_bubble(ID_EX_bubble),
    .EX_MEM_bubble(EX_MEM_bubble), .pc_sel_target(pc_sel_target),
    .dmem_req(dmem_req), .ind_phase2(ind_phase2), .ind_ptr_load(ind_ptr_load),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // Output bundle: {5 loads pc..MEM_WB, 3 bubbles IF_ID..EX_MEM, sel, dreq, ph2, ptr}
  assign dut_out = {pc_load, IF_ID_load, ID_EX_load, EX_MEM_load, MEM_WB_load,
                    IF_ID_bubble, ID_EX_bubble, EX_MEM_bubble,
                    pc_sel_target, dmem_req, ind_phase2, ind_ptr_load};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    string      name;
    logic [2:0] s1, s2;
    logic       u1, u2, mr;
    logic [2:0] d;
    logic       mo, bt, im, dr;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input string n, input logic [2:0] s1, input logic [2:0] s2,
                     input logic u1, input logic u2, input logic mr, input logic [2:0] d,
                     input logic mo, input logic bt, input logic im, input logic dr,
                     input logic [11:0] e);
    vec_t v;
    v.name = n; v.s1 = s1; v.s2 = s2; v.u1 = u1; v.u2 = u2; v.mr = mr; v.d = d;
    v.mo = mo; v.bt = bt; v.im = im; v.dr = dr; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    sr1 = 3'd0; sr2 = 3'd0; dest = 3'd7; use1 = 0; use2 = 0; mrd = 0;
    mop = 0; ind = 0; br = 0; imem = 1; dresp = 0;
  endtask

  // Behavioural model. phase: 0 = no indirect access in flight,
  // 1 = waiting for pointer read, 2 = waiting for data access.
  function automatic logic [11:0] model(input logic [2:0] s1, input logic [2:0] s2,
      input logic u1, input logic u2, input logic mr, input logic [2:0] d,
      input logic mo, input logic id, input logic bt, input logic im,
      input logic dr, input int phase);
    logic dep, lu, done, freeze, fl, fetch_hold, imiss;
    dep    = (u1 && s1 == d) || (u2 && s2 == d);
    lu     = mr && dep;
    if (!mo)     done = 1'b1;
    else if (id) done = (phase == 2) && dr;
    else         done = dr;
    freeze = mo && !done;
    fl     = !freeze && bt;
    imiss  = !freeze && !fl && !lu && !im;
    fetch_hold = !freeze && !fl && (lu || !im);
    return {!freeze && !fetch_hold, !freeze && !(!fl && lu), !freeze, !freeze, !freeze,
            fl || imiss, fl || (!freeze && !fl && lu), fl,
            fl, mo, phase == 2, (phase == 1) && dr};
  endfunction

  int phase_m;
  int stall_m, flush_m;
  int sat;
  logic [11:0] e;

  initial begin
    sat = (1 << CW) - 1;
    idle_inputs();
    rst = 1'b1;
    mop = 1; ind = 1; dresp = 1;
    #2;
    check("reset_outputs", dut_out, {5'b00000, 3'b111, 4'b0000});
    check("reset_stall_cnt", stall_cycles, 0);
    check("reset_flush_cnt", flush_count, 0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1 check("after_reset_run", dut_out, {5'b11111, 3'b000, 4'b0000});

    // imem miss for three cycles
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      imem = 0;
      #1 check("imem_miss", dut_out, {5'b01111, 3'b100, 4'b0000});
      @(negedge clk);
    end
    imem = 1;
    #1 check("imem_recover", dut_out, {5'b11111, 3'b000, 4'b0000});
    check("imem_stall_cnt", stall_cycles, CNT_ON ? 3 : 0);
    check("imem_flush_cnt", flush_count, 0);

    // Directed single-cycle vectors (FSM idle)
    add("run",          0,0, 0,0, 0, 0, 0,0,1,0, {5'b11111,3'b000,4'b0000});
    add("loaduse_sr1",  1,3, 1,1, 1, 1, 0,0,1,0, {5'b00111,3'b010,4'b0000});
    add("false_dep",    2,1, 1,0, 1, 1, 0,0,1,0, {5'b11111,3'b000,4'b0000});
    add("loaduse_sr2",  0,5, 0,1, 1, 5, 0,0,1,0, {5'b00111,3'b010,4'b0000});
    add("match_noload", 4,4, 1,1, 0, 4, 0,0,1,0, {5'b11111,3'b000,4'b0000});
    add("imem_miss1",   0,0, 0,0, 0, 0, 0,0,0,0, {5'b01111,3'b100,4'b0000});
    add("lu_over_imiss",6,0, 1,0, 1, 6, 0,0,0,0, {5'b00111,3'b010,4'b0000});
    add("branch",       0,0, 0,0, 0, 0, 0,1,1,0, {5'b11111,3'b111,4'b1000});
    add("br_over_imiss",0,0, 0,0, 0, 0, 0,1,0,0, {5'b11111,3'b111,4'b1000});
    add("br_over_lu",   2,0, 1,0, 1, 2, 0,1,1,0, {5'b11111,3'b111,4'b1000});
    add("dmem_stall",   0,0, 0,0, 0, 0, 1,0,1,0, {5'b00000,3'b000,4'b0100});
    add("dmem_hit",     0,0, 0,0, 0, 0, 1,0,1,1, {5'b11111,3'b000,4'b0100});
    add("dstall_br",    3,0, 1,0, 1, 3, 1,1,0,0, {5'b00000,3'b000,4'b0100});
    add("dhit_br",      0,0, 0,0, 0, 0, 1,1,1,1, {5'b11111,3'b111,4'b1100});
    add("stray_dresp",  0,0, 0,0, 0, 0, 0,0,1,1, {5'b11111,3'b000,4'b0000});
    foreach (vecs[i]) begin
      @(negedge clk);
      sr1 = vecs[i].s1; sr2 = vecs[i].s2; use1 = vecs[i].u1; use2 = vecs[i].u2;
      mrd = vecs[i].mr; dest = vecs[i].d; mop = vecs[i].mo; ind = 0;
      br = vecs[i].bt; imem = vecs[i].im; dresp = vecs[i].dr;
      #1 check(vecs[i].name, dut_out, vecs[i].exp);
    end

    // LDI: responses at cycles 3 and 6 after entry
    @(negedge clk);
    idle_inputs();
    mop = 1; ind = 1;
    for (int c = 0; c <= 6; c++) begin
      dresp = (c == 3 || c == 6);
      #1 check($sformatf("ldi_c%0d", c), dut_out,
               {(c < 6) ? 5'b00000 : 5'b11111, 3'b000, 2'b01,
                1'(c >= 4), 1'(c == 3)});
      @(negedge clk);
    end
    idle_inputs();
    #1 check("ldi_back_idle", dut_out, {5'b11111, 3'b000, 4'b0000});

    // Taken branch during a 4-cycle dmem miss
    @(negedge clk);
    mop = 1; br = 1;
    for (int c = 0; c <= 4; c++) begin
      dresp = (c == 4);
      #1 check($sformatf("brmiss_c%0d", c), dut_out,
               (c < 4) ? {5'b00000, 3'b000, 4'b0100} : {5'b11111, 3'b111, 4'b1100});
      @(negedge clk);
    end
    idle_inputs();

    // Async reset during IND_SECOND
    mop = 1; ind = 1; dresp = 0;
    @(negedge clk);
    dresp = 1;
    @(negedge clk);
    dresp = 0;
    #1 check("ind2_entered", dut_out, {5'b00000, 3'b000, 4'b0110});
    #2 rst = 1'b1;
    #1 check("async_rst_outputs", dut_out, {5'b00000, 3'b111, 4'b0000});
    @(negedge clk);
    rst = 1'b0;
    dresp = 1;
    #1 check("post_rst_idle", dut_out, {5'b00000, 3'b000, 4'b0100});
    check("post_rst_stall_cnt", stall_cycles, 0);
    check("post_rst_flush_cnt", flush_count, 0);

    // Clean restart for the randomized run
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    phase_m = 0; stall_m = 0; flush_m = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      sr1 = 3'($urandom_range(0, 3)); sr2 = 3'($urandom_range(0, 3));
      dest = 3'($urandom_range(0, 3));
      use1 = 1'($urandom); use2 = 1'($urandom); mrd = 1'($urandom);
      br = ($urandom_range(0, 3) == 0); imem = ($urandom_range(0, 3) != 0);
      dresp = 1'($urandom);
      if (phase_m != 0) begin
        mop = 1; ind = 1;
      end else begin
        mop = 1'($urandom);
        ind = mop && ($urandom_range(0, 3) == 0);
      end
      #1;
      e = model(sr1, sr2, use1, use2, mrd, dest, mop, ind, br, imem, dresp, phase_m);
      check("rand_out", dut_out, e);
      check("rand_stall_cnt", stall_cycles, CNT_ON ? stall_m : 0);
      check("rand_flush_cnt", flush_count, CNT_ON ? flush_m : 0);
      @(posedge clk);
      if (!e[11]) stall_m = (stall_m < sat) ? stall_m + 1 : sat;
      if (e[3])   flush_m = (flush_m < sat) ? flush_m + 1 : sat;
      if (phase_m == 0 && ind)    phase_m = 1;
      else if (phase_m != 0 && dresp) phase_m = (phase_m + 1) % 3;
    end
    @(negedge clk);
    check("final_stall_cnt", stall_cycles, CNT_ON ? stall_m : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
